// File: rtl/mem_burst_reader.sv
// Burst read initiator: issues sequential reads to a 1-cycle-latency memory and
// streams the returned words out on a valid/ready interface with last-word marking.
module mem_burst_reader #(
    parameter int BIT_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_start_addr,
    input  logic [ADDRESS_WIDTH:0]   i_burst_len,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_mem_read,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    input  logic [BIT_WIDTH-1:0]     i_mem_q,
    output logic [BIT_WIDTH-1:0]     o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_out_last
);

    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DONE
    } state_t;

    state_t               r_state;
    logic [AW:0]          r_issue_cnt;
    logic [AW:0]          r_ret_cnt;
    logic [AW-1:0]        r_addr;
    logic                 r_inflight;
    logic [BIT_WIDTH-1:0] r_fifo [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic [2:0]           w_occ;
    logic                 w_mem_read;

    // Occupancy after this cycle's pop; the in-flight word must always have a FIFO slot.
    always_comb begin
        w_valid    = (r_count != 2'd0);
        w_pop      = w_valid && i_out_ready;
        w_push     = r_inflight;
        w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_mem_read = (r_state == ST_BURST) && (r_issue_cnt != '0) && (w_occ < 3'd2);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_addr      <= '0;
            r_inflight  <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
        end else begin
            assert (!(w_push && !w_pop && r_count == 2'd2));
            r_inflight <= w_mem_read;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_mem_q;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr  <= ~r_rd_ptr;
                r_ret_cnt <= r_ret_cnt - 1'b1;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_mem_read) begin
                r_addr      <= r_addr + 1'b1;
                r_issue_cnt <= r_issue_cnt - 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_issue_cnt <= i_burst_len;
                        r_ret_cnt   <= i_burst_len;
                        r_addr      <= i_start_addr;
                        r_state     <= (i_burst_len == '0) ? ST_DONE : ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_pop && r_ret_cnt == 1) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state == ST_BURST);
    assign o_done      = (r_state == ST_DONE);
    assign o_mem_read  = w_mem_read;
    assign o_mem_addr  = r_addr;
    assign o_out_valid = w_valid;
    assign o_out_data  = r_fifo[r_rd_ptr];
    assign o_out_last  = w_valid && (r_ret_cnt == 1);

endmodule
